// File: rtl/vc_arbiter_pkg.sv
// Shared types and constants for the virtual-channel arbiter.
// Optional round-robin arbitration is enabled with `define ARB_ROUND_ROBIN_EN.
package vc_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } arb_state_e;

    localparam logic VC0_IDX = 1'b0;
    localparam logic VC1_IDX = 1'b1;
    localparam logic DST_D0  = 1'b0;
    localparam logic DST_D1  = 1'b1;

    localparam int DATA_W_DEF   = 6;
    localparam int DEST_BIT_DEF = 4;
    localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/vc_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vc_arbiter.sv
// Moves words from VC0/VC1 FIFOs into destination FIFOs D0/D1, one per cycle.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is strict VC0 priority.
module vc_arbiter
    import vc_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEST_BIT = DEST_BIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_afull,
    input  logic              d1_afull,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic              d1_push,
    output logic [DATA_W-1:0] d_data,
    output logic [CNT_W-1:0]  cnt_vc0,
    output logic [CNT_W-1:0]  cnt_vc1,
    output logic              paused
);

    arb_state_e        state_q, state_d;
    logic              xfer_en;
    logic              vc0_elig, vc1_elig;
    logic              gnt0, gnt1;
    logic [DATA_W-1:0] pop_word;
    logic              d0_push_q, d0_push_d;
    logic              d1_push_q, d1_push_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;

    always_comb begin
        state_d = state_q;
        if (!active) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:   state_d = ST_RUN;
                ST_RUN:   if (d0_afull || d1_afull) state_d = ST_PAUSE;
                ST_PAUSE: if (!d0_afull && !d1_afull) state_d = ST_RUN;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // PAUSE still transfers: each VC is gated only by its own head's destination.
    assign xfer_en  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign vc0_elig = xfer_en && !vc0_empty &&
                      !((vc0_data[DEST_BIT] == DST_D1) ? d1_afull : d0_afull);
    assign vc1_elig = xfer_en && !vc1_empty &&
                      !((vc1_data[DEST_BIT] == DST_D1) ? d1_afull : d0_afull);

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ptr_d = ptr_q;
        if (vc0_elig && vc1_elig) begin
            if (ptr_q == VC1_IDX) gnt1 = 1'b1;
            else                  gnt0 = 1'b1;
        end else begin
            gnt0 = vc0_elig;
            gnt1 = vc1_elig;
        end
        if (gnt0) ptr_d = VC1_IDX;
        if (gnt1) ptr_d = VC0_IDX;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= VC0_IDX;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt0 = vc0_elig;
        gnt1 = vc1_elig && !vc0_elig;
    end
`endif

    assign pop_word = gnt0 ? vc0_data : vc1_data;

    always_comb begin
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;
        d_data_d  = d_data_q;
        if (gnt0 || gnt1) begin
            d0_push_d = (pop_word[DEST_BIT] == DST_D0);
            d1_push_d = (pop_word[DEST_BIT] == DST_D1);
            d_data_d  = pop_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            d_data_q  <= '0;
        end else begin
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
            d_data_q  <= d_data_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_vc0 (
        .clk   (clk),
        .reset (reset),
        .inc   (gnt0),
        .clear (1'b0),
        .cnt   (cnt_vc0)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_vc1 (
        .clk   (clk),
        .reset (reset),
        .inc   (gnt1),
        .clear (1'b0),
        .cnt   (cnt_vc1)
    );

    assign vc0_pop = gnt0;
    assign vc1_pop = gnt1;
    assign d0_push = d0_push_q;
    assign d1_push = d1_push_q;
    assign d_data  = d_data_q;
    assign paused  = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed-vector bench for vc_arbiter with hand-computed expectations.
module tb_vc_arbiter;

    logic       clk;
    logic       reset;
    logic       active;
    logic       vc0_empty, vc1_empty;
    logic [5:0] vc0_data, vc1_data;
    logic       d0_afull, d1_afull;
    logic       vc0_pop, vc1_pop;
    logic       d0_push, d1_push;
    logic [5:0] d_data;
    logic [7:0] cnt_vc0, cnt_vc1;
    logic       paused;

    int n_cmp = 0;
    int n_err = 0;

    vc_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .vc0_empty (vc0_empty),
        .vc1_empty (vc1_empty),
        .vc0_data  (vc0_data),
        .vc1_data  (vc1_data),
        .d0_afull  (d0_afull),
        .d1_afull  (d1_afull),
        .vc0_pop   (vc0_pop),
        .vc1_pop   (vc1_pop),
        .d0_push   (d0_push),
        .d1_push   (d1_push),
        .d_data    (d_data),
        .cnt_vc0   (cnt_vc0),
        .cnt_vc1   (cnt_vc1),
        .paused    (paused)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int         exp_vc[4];
    logic [5:0] word;

    initial begin
        reset = 1'b1; active = 1'b0;
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        vc0_data = '0; vc1_data = '0;
        d0_afull = 1'b0; d1_afull = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_pop0", vc0_pop, 0);
        chk("rst_pop1", vc1_pop, 0);
        chk("rst_push0", d0_push, 0);
        chk("rst_push1", d1_push, 0);
        chk("rst_data", d_data, 0);
        chk("rst_cnt0", cnt_vc0, 0);
        chk("rst_cnt1", cnt_vc1, 0);
        chk("rst_paused", paused, 0);

        // Two words from VC0 to D0 then D1
        active = 1'b1; vc0_empty = 1'b0; vc0_data = 6'h05;
        #1 chk("t2_off_nopop", vc0_pop, 0);
        tick();
        chk("t2_pop_a", vc0_pop, 1);
        chk("t2_nopop1", vc1_pop, 0);
        tick();
        vc0_data = 6'h15;
        chk("t2_push0_a", d0_push, 1);
        chk("t2_push1_a", d1_push, 0);
        chk("t2_data_a", d_data, 6'h05);
        #1 chk("t2_pop_b", vc0_pop, 1);
        tick();
        vc0_empty = 1'b1;
        chk("t2_push1_b", d1_push, 1);
        chk("t2_push0_b", d0_push, 0);
        chk("t2_data_b", d_data, 6'h15);
        chk("t2_cnt0", cnt_vc0, 2);
        #1 chk("t2_empty_nopop", vc0_pop, 0);
        tick();
        chk("t2_idle_push0", d0_push, 0);
        chk("t2_idle_push1", d1_push, 0);
        chk("t2_hold_data", d_data, 6'h15);
        chk("t2_idle_paused", paused, 0);

        // Asynchronous reset with a transfer in flight
        vc0_empty = 1'b0; vc0_data = 6'h05;
        #1 chk("t1_pop", vc0_pop, 1);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t1_async_pop0", vc0_pop, 0);
        chk("t1_async_push0", d0_push, 0);
        chk("t1_async_data", d_data, 0);
        chk("t1_async_cnt0", cnt_vc0, 0);
        chk("t1_async_paused", paused, 0);
        tick();
        chk("t1_next_push0", d0_push, 0);
        chk("t1_next_push1", d1_push, 0);
        vc0_empty = 1'b1;
        reset = 1'b0;
        tick();

        // Both VCs loaded: strict drains VC0 first, round-robin alternates
        q0 = '{6'h01, 6'h02};
        q1 = '{6'h11, 6'h12};
`ifdef ARB_ROUND_ROBIN_EN
        exp_vc = '{0, 1, 0, 1};
`else
        exp_vc = '{0, 0, 1, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            vc0_empty = (q0.size() == 0);
            vc0_data  = (q0.size() != 0) ? q0[0] : 6'h00;
            vc1_empty = (q1.size() == 0);
            vc1_data  = (q1.size() != 0) ? q1[0] : 6'h00;
            #1;
            chk($sformatf("t3_pop0_%0d", i), vc0_pop, (exp_vc[i] == 0));
            chk($sformatf("t3_pop1_%0d", i), vc1_pop, (exp_vc[i] == 1));
            word = (exp_vc[i] == 0) ? q0.pop_front() : q1.pop_front();
            tick();
            chk($sformatf("t3_data_%0d", i), d_data, word);
            chk($sformatf("t3_push0_%0d", i), d0_push, !word[4]);
            chk($sformatf("t3_push1_%0d", i), d1_push, word[4]);
        end
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        tick();
        chk("t3_done_push0", d0_push, 0);
        chk("t3_done_push1", d1_push, 0);

        // D0 almost-full: VC1 bypasses the blocked VC0
        d0_afull = 1'b1;
        vc0_empty = 1'b0; vc0_data = 6'h03;
        vc1_empty = 1'b0; vc1_data = 6'h12;
        #1;
        chk("t4_blk_pop0", vc0_pop, 0);
        chk("t4_pop1", vc1_pop, 1);
        tick();
        vc1_empty = 1'b1;
        chk("t4_paused", paused, 1);
        chk("t4_push1", d1_push, 1);
        chk("t4_data", d_data, 6'h12);
        #1 chk("t4_blk_pop0_b", vc0_pop, 0);
        tick();
        chk("t4_paused_b", paused, 1);
        chk("t4_nopush1", d1_push, 0);
        chk("t4_blk_pop0_c", vc0_pop, 0);
        d0_afull = 1'b0;
        #1;
        chk("t4_unblk_pop0", vc0_pop, 1);
        chk("t4_paused_c", paused, 1);
        tick();
        vc0_empty = 1'b1;
        chk("t4_resume", paused, 0);
        chk("t4_push0", d0_push, 1);
        chk("t4_data_b", d_data, 6'h03);

        // active drops in the cycle VC1 is popped
        vc1_empty = 1'b0; vc1_data = 6'h14; active = 1'b0;
        #1 chk("t5_pop1", vc1_pop, 1);
        tick();
        vc1_data = 6'h13;
        chk("t5_push1", d1_push, 1);
        chk("t5_data", d_data, 6'h14);
        #1;
        chk("t5_off_pop1", vc1_pop, 0);
        chk("t5_off_pop0", vc0_pop, 0);
        tick();
        chk("t5_off_push1", d1_push, 0);
        chk("t5_off_push0", d0_push, 0);
        chk("t5_off_pop1_b", vc1_pop, 0);
        vc1_empty = 1'b1;

        // Counter saturation on VC0
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk("t6_cnt_clr", cnt_vc0, 0);
        active = 1'b1; vc0_empty = 1'b0; vc0_data = 6'h00;
        tick();
        repeat (254) tick();
        chk("t6_cnt_254", cnt_vc0, 8'hFE);
        tick();
        chk("t6_cnt_255", cnt_vc0, 8'hFF);
        tick();
        chk("t6_cnt_sat", cnt_vc0, 8'hFF);
        vc0_empty = 1'b1;
        tick();
        chk("t6_cnt_hold", cnt_vc0, 8'hFF);
        chk("t6_cnt1", cnt_vc1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
